// File: rtl/wall_overlay_renderer.sv
// Final pixel compositor for the wall game: depth-shaded wall, goal-window and collision
// highlights, per-frame collision statistics and the game-over flash sequence.
module wall_overlay_renderer #(
    parameter int SCREEN_WIDTH        = 1280,
    parameter int SCREEN_HEIGHT       = 720,
    parameter int GOAL_DEPTH          = 60,
    parameter int GOAL_DEPTH_DELTA    = 10,
    parameter int FLASH_FRAMES        = 32,
    parameter int COLLISION_THRESHOLD = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [15:0] pixel_in,
    input  logic        data_valid_in,
    input  logic        is_wall_in,
    input  logic        is_person_in,
    input  logic        is_collision_in,
    input  logic [7:0]  wall_depth_in,
    input  logic [2:0]  game_state_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [15:0] pixel_out,
    output logic        data_valid_out,
    output logic [19:0] collision_count_out,
    output logic        frame_done_out,
    output logic        bad_frame_out,
    output logic [1:0]  fsm_state_out
);
    localparam int               CNT_W      = $clog2(FLASH_FRAMES);
    localparam logic [10:0]      LAST_H     = 11'(SCREEN_WIDTH - 1);
    localparam logic [9:0]       LAST_V     = 10'(SCREEN_HEIGHT - 1);
    localparam logic [7:0]       WIN_LO     = 8'(GOAL_DEPTH - GOAL_DEPTH_DELTA);
    localparam logic [7:0]       WIN_HI     = 8'(GOAL_DEPTH + GOAL_DEPTH_DELTA);
    localparam logic [19:0]      BAD_LEVEL  = 20'(COLLISION_THRESHOLD);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {PLAY = 2'd0, HIT_FLASH = 2'd1, OVER = 2'd2} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic        frame_end;
    logic        in_window_d;
    logic [4:0]  level_d;
    logic [15:0] wall_color_d;

    logic        s1_valid_q, s1_wall_q, s1_person_q, s1_coll_q, s1_win_q;
    logic [10:0] s1_hc_q;
    logic [9:0]  s1_vc_q;
    logic [15:0] s1_pix_q, s1_wcolor_q;

    logic [4:0]  avg_r, avg_b;
    logic [5:0]  avg_g;
    logic [15:0] mix_d, pix_d;

    logic        out_valid_q, done_q, bad_q;
    logic [10:0] out_hc_q;
    logic [9:0]  out_vc_q;
    logic [15:0] out_pix_q;
    logic [19:0] acc_q, acc_d, count_q;

    // Stage 1 colour prep: depth/2 saturates to 31 once depth reaches 64.
    always_comb begin
        frame_end    = data_valid_in && (hcount_in == LAST_H) && (vcount_in == LAST_V);
        in_window_d  = (wall_depth_in >= WIN_LO) && (wall_depth_in <= WIN_HI);
        level_d      = (wall_depth_in[7:6] != 2'b00) ? 5'd31 : wall_depth_in[5:1];
        wall_color_d = in_window_d ? 16'hFFE0 : {level_d, level_d, 1'b0, level_d};
        acc_d        = acc_q;
        if (data_valid_in && is_collision_in && (acc_q != 20'hFFFFF))
            acc_d = acc_q + 20'd1;
    end

    always_comb begin
        avg_r = 5'(({1'b0, s1_pix_q[15:11]} + {1'b0, s1_wcolor_q[15:11]}) >> 1);
        avg_g = 6'(({1'b0, s1_pix_q[10:5]}  + {1'b0, s1_wcolor_q[10:5]})  >> 1);
        avg_b = 5'(({1'b0, s1_pix_q[4:0]}   + {1'b0, s1_wcolor_q[4:0]})   >> 1);
        if (s1_coll_q && s1_win_q)
            mix_d = 16'hF800;
        else if (s1_coll_q)
            mix_d = 16'hFC00;
        else if (s1_wall_q && s1_person_q)
            mix_d = {avg_r, avg_g, avg_b};
        else if (s1_wall_q)
            mix_d = s1_wcolor_q;
        else
            mix_d = s1_pix_q;
        case (state_q)
            HIT_FLASH: pix_d = frame_cnt_q[2] ? ~mix_d : mix_d;
            OVER:      pix_d = {1'b0, mix_d[15:12], 1'b0, mix_d[10:6], 1'b0, mix_d[4:1]};
            default:   pix_d = mix_d;
        endcase
        if (!s1_valid_q)
            pix_d = 16'h0000;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_valid_q  <= 1'b0;
            s1_wall_q   <= 1'b0;
            s1_person_q <= 1'b0;
            s1_coll_q   <= 1'b0;
            s1_win_q    <= 1'b0;
            s1_hc_q     <= '0;
            s1_vc_q     <= '0;
            s1_pix_q    <= '0;
            s1_wcolor_q <= '0;
            out_valid_q <= 1'b0;
            out_hc_q    <= '0;
            out_vc_q    <= '0;
            out_pix_q   <= '0;
        end else begin
            s1_valid_q  <= data_valid_in;
            s1_wall_q   <= is_wall_in;
            s1_person_q <= is_person_in;
            s1_coll_q   <= is_collision_in;
            s1_win_q    <= in_window_d;
            s1_hc_q     <= hcount_in;
            s1_vc_q     <= vcount_in;
            s1_pix_q    <= pixel_in;
            s1_wcolor_q <= wall_color_d;
            out_valid_q <= s1_valid_q;
            out_hc_q    <= s1_hc_q;
            out_vc_q    <= s1_vc_q;
            out_pix_q   <= pix_d;
        end
    end

    // The frame-end pixel itself is included in the count it latches.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else if (frame_end) begin
            acc_q   <= '0;
            count_q <= acc_d;
            done_q  <= 1'b1;
            bad_q   <= (acc_d >= BAD_LEVEL);
        end else begin
            acc_q   <= acc_d;
            done_q  <= 1'b0;
        end
    end

    // game_state_in is only looked at on the frame-end pixel, so a frame never tears.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= PLAY;
            frame_cnt_q <= '0;
        end else if (frame_end) begin
            case (state_q)
                PLAY: begin
                    if (game_state_in == 3'd0) begin
                        state_q     <= HIT_FLASH;
                        frame_cnt_q <= '0;
                    end
                end
                HIT_FLASH: begin
                    if (game_state_in != 3'd0)
                        state_q <= PLAY;
                    else if (frame_cnt_q == FLASH_LAST)
                        state_q <= OVER;
                    else
                        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                end
                OVER: begin
                    if (game_state_in != 3'd0)
                        state_q <= PLAY;
                end
                default: state_q <= PLAY;
            endcase
        end
    end

    assign hcount_out          = out_hc_q;
    assign vcount_out          = out_vc_q;
    assign pixel_out           = out_pix_q;
    assign data_valid_out      = out_valid_q;
    assign collision_count_out = count_q;
    assign frame_done_out      = done_q;
    assign bad_frame_out       = bad_q;
    assign fsm_state_out       = state_q;
endmodule

// File: tb/tb_wall_overlay_renderer.sv
// Directed and randomized checks of wall_overlay_renderer against a channel-level colour
// model, a per-frame collision tally and a play/flash/over mode tracker.
module tb_wall_overlay_renderer;
    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [15:0] pixel_in;
    logic        data_valid_in, is_wall_in, is_person_in, is_collision_in;
    logic [7:0]  wall_depth_in;
    logic [2:0]  game_state_in;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [15:0] pixel_out;
    logic        data_valid_out, frame_done_out, bad_frame_out;
    logic [19:0] collision_count_out;
    logic [1:0]  fsm_state_out;

    always #5 clk = ~clk;

    wall_overlay_renderer dut (
        .clk_in(clk), .rst_in(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .pixel_in(pixel_in),
        .data_valid_in(data_valid_in), .is_wall_in(is_wall_in), .is_person_in(is_person_in),
        .is_collision_in(is_collision_in), .wall_depth_in(wall_depth_in),
        .game_state_in(game_state_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .pixel_out(pixel_out),
        .data_valid_out(data_valid_out), .collision_count_out(collision_count_out),
        .frame_done_out(frame_done_out), .bad_frame_out(bad_frame_out),
        .fsm_state_out(fsm_state_out)
    );

    // Expected output word per driven pixel: {valid, hcount, vcount, pixel}.
    logic [37:0] exp_q[$];
    int pass_cnt = 0;
    int fail_cnt = 0;
    int check_cnt = 0;

    // Reference model: mode 0 = playing, 1 = flashing, 2 = game over.
    int          mode;
    int          flash_n;
    int          acc;
    logic [19:0] exp_count;
    logic        exp_done, exp_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        check_cnt++;
        assert (got === want) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] ref_pixel(input logic [15:0] pix, input bit valid,
                                              input bit wall, input bit person, input bit coll,
                                              input int depth);
        int r, g, b, wr, wg, wb, lvl;
        bit win;
        win = (depth >= 60 - 10) && (depth <= 60 + 10);
        lvl = depth / 2;
        if (lvl > 31) lvl = 31;
        if (win) begin wr = 31; wg = 63; wb = 0; end
        else begin wr = lvl; wg = 2 * lvl; wb = lvl; end
        r = int'(pix[15:11]);
        g = int'(pix[10:5]);
        b = int'(pix[4:0]);
        if (coll && win) begin r = 31; g = 0; b = 0; end
        else if (coll) begin r = 31; g = 32; b = 0; end
        else if (wall && person) begin r = (r + wr) / 2; g = (g + wg) / 2; b = (b + wb) / 2; end
        else if (wall) begin r = wr; g = wg; b = wb; end
        if (mode == 1 && ((flash_n / 4) % 2) == 1) begin
            r = 31 - r; g = 63 - g; b = 31 - b;
        end else if (mode == 2) begin
            r = r / 2; g = g / 2; b = b / 2;
        end
        if (!valid) return 16'h0000;
        return {5'(r), 6'(g), 5'(b)};
    endfunction

    task automatic model_reset();
        mode = 0;
        flash_n = 0;
        acc = 0;
        exp_count = '0;
        exp_done = 1'b0;
        exp_bad = 1'b0;
        exp_q.delete();
        exp_q.push_back(38'd0);
    endtask

    task automatic drive(input logic [10:0] hc, input logic [9:0] vc, input logic [15:0] pix,
                         input bit valid, input bit wall, input bit person, input bit coll,
                         input logic [7:0] depth, input logic [2:0] gs);
        logic [37:0] e;
        bit fe;
        hcount_in = hc; vcount_in = vc; pixel_in = pix; data_valid_in = valid;
        is_wall_in = wall; is_person_in = person; is_collision_in = coll;
        wall_depth_in = depth; game_state_in = gs;
        fe = valid && hc == 11'd1279 && vc == 10'd719;
        exp_done = 1'b0;
        if (valid && coll && acc < 1048575) acc++;
        if (fe) begin
            exp_count = 20'(acc);
            exp_bad = (acc >= 64);
            exp_done = 1'b1;
            acc = 0;
            if (mode == 0) begin
                if (gs == 0) begin mode = 1; flash_n = 0; end
            end else if (mode == 1) begin
                if (gs != 0) mode = 0;
                else if (flash_n == 31) mode = 2;
                else flash_n++;
            end else if (gs != 0) begin
                mode = 0;
            end
        end
        exp_q.push_back({valid, hc, vc, ref_pixel(pix, valid, wall, person, coll, int'(depth))});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pixel_out", 32'(pixel_out), 32'(e[15:0]));
        check("data_valid_out", 32'(data_valid_out), 32'(e[37]));
        check("hcount_out", 32'(hcount_out), 32'(e[36:26]));
        check("vcount_out", 32'(vcount_out), 32'(e[25:16]));
        check("frame_done_out", 32'(frame_done_out), 32'(exp_done));
        check("collision_count_out", 32'(collision_count_out), 32'(exp_count));
        check("bad_frame_out", 32'(bad_frame_out), 32'(exp_bad));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pixel_out"}, 32'(pixel_out), 32'd0);
        check({tag, " data_valid_out"}, 32'(data_valid_out), 32'd0);
        check({tag, " hcount_out"}, 32'(hcount_out), 32'd0);
        check({tag, " vcount_out"}, 32'(vcount_out), 32'd0);
        check({tag, " collision_count_out"}, 32'(collision_count_out), 32'd0);
        check({tag, " frame_done_out"}, 32'(frame_done_out), 32'd0);
        check({tag, " bad_frame_out"}, 32'(bad_frame_out), 32'd0);
    endtask

    task automatic random_frame(input int n, input logic [2:0] gs_mid, input logic [2:0] gs_end);
        logic [7:0] depth;
        bit w, p;
        depth = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(50, 70)) : 8'($urandom_range(0, 255));
        for (int i = 0; i < n; i++) begin
            w = 1'($urandom_range(0, 1));
            p = 1'($urandom_range(0, 1));
            drive(11'($urandom_range(0, 1278)), 10'($urandom_range(0, 719)), 16'($urandom),
                  $urandom_range(0, 7) != 0, w, p, w && p && ($urandom_range(0, 1) == 1), depth, gs_mid);
        end
        w = 1'($urandom_range(0, 1));
        p = 1'($urandom_range(0, 1));
        drive(11'd1279, 10'd719, 16'($urandom), 1'b1, w, p, w && p && ($urandom_range(0, 1) == 1),
              depth, gs_end);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        hcount_in = '0; vcount_in = '0; pixel_in = '0; data_valid_in = 1'b0;
        is_wall_in = 1'b0; is_person_in = 1'b0; is_collision_in = 1'b0;
        wall_depth_in = '0; game_state_in = 3'd1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Shaded wall pixel at depth 20 between plain camera pixels.
        drive(11'd4, 10'd5, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 8'd20, 3'd1);
        drive(11'd5, 10'd5, 16'h5678, 1'b1, 1'b1, 1'b0, 1'b0, 8'd20, 3'd1);
        drive(11'd6, 10'd5, 16'h9ABC, 1'b1, 1'b0, 1'b0, 1'b0, 8'd20, 3'd1);
        // Wall over player, black camera pixel, then an invalid pixel.
        drive(11'd7, 10'd5, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 8'd20, 3'd1);
        drive(11'd8, 10'd5, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'd20, 3'd1);
        drive(11'd1279, 10'd719, 16'h0F0F, 1'b1, 1'b0, 1'b0, 1'b0, 8'd20, 3'd1);

        // 100 in-window collisions: bad frame.
        for (int i = 0; i < 100; i++)
            drive(11'(i), 10'd100, 16'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 8'd60, 3'd1);
        drive(11'd1279, 10'd719, 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0, 8'd60, 3'd1);
        // Threshold edges: 63 then 64 collisions.
        for (int i = 0; i < 63; i++)
            drive(11'(i), 10'd3, 16'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 8'd90, 3'd1);
        drive(11'd1279, 10'd719, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd90, 3'd1);
        for (int i = 0; i < 63; i++)
            drive(11'(i), 10'd4, 16'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 8'd200, 3'd1);
        drive(11'd1279, 10'd719, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 8'd200, 3'd1);

        // Collision on the last pixel, then a fresh frame counting from zero.
        drive(11'd10, 10'd10, 16'h1111, 1'b1, 1'b1, 1'b1, 1'b1, 8'd30, 3'd1);
        drive(11'd11, 10'd10, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b1, 8'd30, 3'd1);
        drive(11'd1279, 10'd719, 16'h3333, 1'b1, 1'b1, 1'b1, 1'b1, 8'd30, 3'd1);
        drive(11'd12, 10'd10, 16'h4444, 1'b1, 1'b1, 1'b1, 1'b1, 8'd30, 3'd1);
        drive(11'd1279, 10'd719, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 8'd30, 3'd1);

        for (int f = 0; f < 4; f++) random_frame($urandom_range(3, 6), 3'd1, 3'd1);

        // Lost mid-frame but playing again at frame end: no transition.
        random_frame(4, 3'd0, 3'd2);
        // Lost: flash for 32 frames, then game over, then back to play.
        for (int f = 0; f < 36; f++) random_frame($urandom_range(2, 4), 3'd0, 3'd0);
        random_frame(3, 3'd0, 3'd5);
        random_frame(3, 3'd1, 3'd1);
        // Recovery straight out of the flash sequence.
        for (int f = 0; f < 6; f++) random_frame(3, 3'd0, 3'd0);
        random_frame(3, 3'd0, 3'd3);
        random_frame(3, 3'd1, 3'd1);

        // Asynchronous reset in mid-line discards partial counts and mode.
        for (int f = 0; f < 3; f++) random_frame(2, 3'd0, 3'd0);
        for (int i = 0; i < 5; i++)
            drive(11'(20 + i), 10'd50, 16'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 8'd55, 3'd0);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(11'd30, 10'd50, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 8'd10, 3'd1);
        drive(11'd31, 10'd50, 16'hCAFE, 1'b1, 1'b0, 1'b0, 1'b0, 8'd10, 3'd1);
        drive(11'd1279, 10'd719, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 8'd10, 3'd1);
        for (int f = 0; f < 3; f++) random_frame($urandom_range(3, 6), 3'd1, 3'd1);
        drive(11'd0, 10'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
